// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, tracks one-cycle imem latency, skid-buffers one response.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects present a single fault entry and halt fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign
);

    logic [31:0] pc_req_q, pc_req_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;

    logic        pres_valid;
    logic [31:0] pres_pc;
    logic [31:0] pres_instr;
    logic        pres_misalign;
    logic        fire;
    logic        issue;
    logic        halt;
    logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StRun, StArm, StShow, StHalt} trap_state_e;
    trap_state_e trap_q, trap_d;

    assign redir_pc = redirect_pc;
    assign halt     = (trap_q != StRun);

    always_comb begin
        trap_d = trap_q;
        if (redirect_valid) begin
            trap_d = (redirect_pc[1:0] != 2'b00) ? StArm : StRun;
        end else begin
            unique case (trap_q)
                StArm:   trap_d = StShow;
                StShow:  trap_d = fire ? StHalt : StShow;
                default: trap_d = trap_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) trap_q <= StRun;
        else     trap_q <= trap_d;
    end
`else
    assign redir_pc = redirect_pc & ~32'h3;
    assign halt     = 1'b0;
`endif

    // Buffer has priority over the live memory response so ordering is preserved.
    always_comb begin
        pres_misalign = 1'b0;
        if (buf_vld_q) begin
            pres_valid = 1'b1;
            pres_pc    = buf_pc_q;
            pres_instr = buf_instr_q;
        end else begin
            pres_valid = rsp_vld_q;
            pres_pc    = rsp_pc_q;
            pres_instr = imem_instr;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        // Buffer and response are empty while trapping; pc_req still holds the bad target.
        if (trap_q == StShow) begin
            pres_valid    = 1'b1;
            pres_pc       = pc_req_q;
            pres_instr    = 32'h0;
            pres_misalign = 1'b1;
        end
`endif
    end

    assign imem_addr   = RST ? RESET_PC : pc_req_q;
    assign if_valid    = pres_valid & ~redirect_valid & ~RST;
    assign if_pc       = RST ? 32'h0 : pres_pc;
    assign if_instr    = RST ? 32'h0 : pres_instr;
    assign if_misalign = pres_misalign & ~RST;
    assign fire        = if_valid & if_ready;

    always_comb begin
        pc_req_d    = pc_req_q;
        rsp_vld_d   = 1'b0;
        rsp_pc_d    = rsp_pc_q;
        buf_vld_d   = buf_vld_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        issue       = 1'b0;

        if (buf_vld_q) begin
            buf_vld_d = ~fire | rsp_vld_q;
            if (fire && rsp_vld_q) begin
                buf_pc_d    = rsp_pc_q;
                buf_instr_d = imem_instr;
            end
        end else begin
            buf_vld_d = rsp_vld_q & ~if_ready;
            if (rsp_vld_q && !if_ready) begin
                buf_pc_d    = rsp_pc_q;
                buf_instr_d = imem_instr;
            end
        end

        issue = ~buf_vld_d & ~halt;
        if (issue) begin
            rsp_vld_d = 1'b1;
            rsp_pc_d  = pc_req_q;
            pc_req_d  = pc_req_q + 32'd4;
        end

        if (redirect_valid) begin
            pc_req_d  = redir_pc;
            rsp_vld_d = 1'b0;
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_req_q    <= RESET_PC;
            rsp_vld_q   <= 1'b0;
            rsp_pc_q    <= 32'h0;
            buf_vld_q   <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
        end else begin
            pc_req_q    <= pc_req_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_pc_q    <= rsp_pc_d;
            buf_vld_q   <= buf_vld_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the synchronous instruction memory. It owns the program counter, drives the memory address, and tracks the memory's one-cycle read latency. It presents each returned instruction with its PC to decode over a valid/ready handshake, using a one-entry skid buffer. It accepts branch/jump redirects from execute, and redirects kill all in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory; equals internal pc_req register
- imem_instr  in  32  instruction memory read data; reflects imem_addr sampled at previous edge
- redirect_valid  in  1  execute requests fetch restart
- redirect_pc  in  32  restart target (byte address)
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts this cycle
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- if_misalign  out  1  presented entry is a misaligned-target fault (see Configuration)

## Operation
- State: pc_req[31:0], rsp_vld, rsp_pc[31:0], buf_vld, buf_pc, buf_instr; plus halt flag when macro is enabled.
- Presentation (combinational): if buf_vld, present buf_pc/buf_instr; else present rsp_pc/imem_instr with if_valid=rsp_vld. fire = if_valid & if_ready.
- Buffer next: buf_vld_n = buf_vld ? (!fire | rsp_vld) : (rsp_vld & !if_ready). On fire from the buffer with rsp_vld=1, the response moves into the buffer. When the buffer is empty, an unaccepted response is captured.
- Issue rule: issue = !buf_vld_n (& !halt). On issue: rsp_pc <= pc_req, rsp_vld <= 1, pc_req <= pc_req + 4 (mod 2^32). Otherwise pc_req holds and rsp_vld <= 0. The memory re-reads the same address and its data is marked invalid.
- Redirect priority: redirect_valid beats issue, buffer and fire logic.
  - Next state: pc_req <= redirect_pc, rsp_vld <= 0, buf_vld <= 0.
  - if_valid is forced 0 in the redirect cycle, so no fire occurs.
- An instruction is never dropped or duplicated except by redirect flush.

## Timing
- Reset values: pc_req=RESET_PC, rsp_vld=0, buf_vld=0, halt=0.
  - Outputs during reset: imem_addr=RESET_PC, if_valid=0, if_misalign=0, if_pc and if_instr=0.
- First instruction: RST low at edge E0 (issue, address RESET_PC). if_valid=1 with if_pc=RESET_PC in the cycle after E0.
- Throughput: one instruction per cycle while if_ready=1.
- Redirect latency: redirect in cycle T puts the target on imem_addr in T+1. The target instruction is valid in T+2; cycles T and T+1 present if_valid=0.
- Stall: if_ready low puts at most one response in the buffer. Fetch stops issuing and resumes one cycle after the buffer empties.
- Reset mid-operation overrides everything, including redirect, and all in-flight or buffered data is discarded.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.

## Configuration
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 loads pc_req and sets halt, and no issue occurs while halted.
  - In T+2, fetch presents if_valid=1, if_misalign=1, if_pc=redirect_pc, if_instr=0, held until fire.
  - After that fire, if_valid=0 until the next redirect or reset, either of which clears halt.
- Undefined: redirect_pc[1:0] is forced to 2'b00, if_misalign is tied 0, and there is no halt state.

## Test plan
- Reset release, RESET_PC=32'h100, if_ready=1: if_pc sequence 0x100,0x104,0x108 on consecutive cycles starting one cycle after reset drops; if_instr matches memory words 64,65,66.
- Stall: if_ready low for 3 cycles mid-stream at if_pc=0x108 -> 0x108 held stable with if_valid=1; after ready returns, sequence continues 0x10C,0x110 with no gap longer than one cycle and no duplicate.
- Redirect to 0x200 during a stall with a full buffer -> buffered entry dropped; if_valid=0 for 2 cycles; then if_pc=0x200,0x204.
- Redirect and RST asserted in the same cycle -> reset wins; imem_addr=RESET_PC next cycle.
- PC wrap: redirect to 0xFFFFFFFC, if_ready=1 -> if_pc 0xFFFFFFFC then 0x00000000.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x302 -> if_misalign=1, if_pc=0x302 two cycles later; after fire, idle; redirect to 0x300 resumes normal fetch. Without the macro: fetch proceeds from 0x300.
